collision_score_unit: RTL and testbench
=======================================

// Module: collision_score_unit
// PURPOSE
// - Downstream consumer of the building mover. Each frame it compares the bird box against both buildings and their window gaps.
// - Counts buildings passed as a BCD score and manages lives with a post-hit invulnerability period.
// - Sequences game state (IDLE/PLAY/INVULN/OVER) for the drawing and display logic.
// PARAMETERS
// - WIDTH_BUILDING  80   building width in pixels; must match the mover
// - WIDTH_BIRD      56   bird box width in pixels
// - HEIGHT_BIRD     56   bird box height in pixels
// - SCREEN_HEIGHT   480  playfield height; the bird touching y<0 or y+HEIGHT_BIRD>SCREEN_HEIGHT is a hit
// - LIVES           3    lives loaded at game start, 1..7
// - INVULN_FRAMES   90   frame ticks of invulnerability after a non-fatal hit
// PORTS
// - clk            in   1   system clock
// - resetN         in   1   asynchronous, active-low reset
// - frame_tick     in   1   one-clk pulse per video frame; all evaluation happens on it
// - start_key      in   1   level; rising edge (sync'd internally, 2 FF) starts/restarts the game
// - bird_x         in   32  signed bird top-left x
// - bird_y         in   32  signed bird top-left y
// - topLeft_x_1    in   32  signed building 1 x
// - topLeft_y_1    in   32  signed building 1 window top y
// - topLeft_x_2    in   32  signed building 2 x
// - topLeft_y_2    in   32  signed building 2 window top y
// - height_window  in   32  window gap height in pixels
// - score_bcd      out  12  three BCD digits, [11:8] is hundreds
// - lives_left     out  3   remaining lives
// - hit_pulse      out  1   one-clk pulse when a hit is registered
// - score_pulse    out  1   one-clk pulse when the score increments
// - invulnerable   out  1   high while in INVULN
// - game_over      out  1   high in OVER
// - playing        out  1   high in PLAY or INVULN
// BEHAVIOUR
// - Reset: state=IDLE, score_bcd=0, lives_left=LIVES, all pulses 0, invulnerable=0, game_over=0, playing=0, passed flags=0, prev_x=0.
// - FSM:
//   - IDLE->PLAY on a start edge: score=0, lives=LIVES, passed flags cleared.
//   - PLAY->INVULN on a hit when lives_left>1: lives-1, inv_cnt=INVULN_FRAMES.
//   - PLAY->OVER on a hit when lives_left==1: lives becomes 0.
//   - INVULN->PLAY when inv_cnt reaches 0; inv_cnt decrements on each frame_tick.
//   - OVER->PLAY on a start edge, with the same init as IDLE->PLAY.
//   - A start edge in PLAY or INVULN is ignored.
// - All geometry is registered on frame_tick. Outputs update 1 clk after the frame_tick that triggered them; pulses are exactly 1 clk wide.
// - Overlap for building i: bird_x+WIDTH_BIRD > x_i AND bird_x < x_i+WIDTH_BUILDING, all as signed 33-bit compares.
// - Gap miss: bird_y < y_i OR bird_y+HEIGHT_BIRD > y_i+height_window.
// - Hit = (overlap_1 & miss_1) | (overlap_2 & miss_2) | bird off screen vertically. Hits are ignored in IDLE, OVER and INVULN.
// - Score for building i:
//   - When passed_i==0 and x_i+WIDTH_BUILDING <= bird_x: set passed_i and add +1.
//   - passed_i clears when x_i > prev_x_i, i.e. the building wrapped to the right edge.
//   - prev_x_i is updated on every frame_tick.
// - Both buildings passing on the same tick add +2 and give a single score_pulse.
// - Scoring happens in PLAY and INVULN. In INVULN only hits are masked; scoring continues.
// - A hit and a pass on the same tick: the score still counts, then the hit is handled.
// - BCD add: ripple with per-digit carry and saturation at 999; no wrap. score_pulse still fires when saturated.
// - Reset mid-game returns to IDLE immediately; no pulse is emitted.
// STRUCTURE
// - Shared package flappy_pkg:
//   - typedef game_state_t {IDLE, PLAY, INVULN, OVER}
//   - SCREEN_WIDTH=640, SCREEN_HEIGHT=480, WIDTH_BUILDING=80 (shared with the mover)
// - Sub-module bcd_score_counter: inputs clk, resetN, clear, inc[1:0]; output 12-bit BCD with saturation.
// - Everything else, including the edge synchroniser, stays inline.
// TESTING
// - Start then idle: pulse start_key, bird at (100,200), buildings at x=600 -> playing=1, lives_left=3, no hit_pulse over 10 frames.
// - Pass: building 1 x steps 40->20 with bird_x=100 (40+80>100, 20+80<=100) -> score_bcd=0x001, one score_pulse. Holding x=20 -> no more increments. x jumps to 639 then decreases past again -> 0x002.
// - Hit and invulnerability: overlap with bird_y=0, y_1=100 -> hit_pulse, lives_left=2, invulnerable=1. 89 further overlapping frames give no hit; returns to PLAY after 90 ticks.
// - Fatal and restart: three hits spaced more than 90 frames apart -> game_over=1, lives_left=0. A start edge gives score 0x000 and lives_left=3.
// - Double pass and saturation: preload score 998, pass both buildings on the same tick -> 0x999, single score_pulse. A further pass stays at 0x999.
// - Reset mid-INVULN: assert resetN=0 -> immediately state IDLE, invulnerable=0, score 0x000, lives_left=3.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game pipeline: game states, screen geometry
// and a sign-extension helper for the 33-bit geometry compares.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } game_state_t;

  localparam int SCREEN_WIDTH   = 640;
  localparam int SCREEN_HEIGHT  = 480;
  localparam int WIDTH_BUILDING = 80;

  function automatic logic signed [32:0] sext33(input logic [31:0] v);
    return {v[31], v};
  endfunction

endpackage

// File: rtl/collision_score_unit_if.sv
// Per-frame geometry in, game status out, between the game logic and the
// collision/score unit.
interface collision_score_unit_if;

  logic               frame_tick;
  logic               start_key;
  logic signed [31:0] bird_x;
  logic signed [31:0] bird_y;
  logic signed [31:0] topLeft_x_1;
  logic signed [31:0] topLeft_y_1;
  logic signed [31:0] topLeft_x_2;
  logic signed [31:0] topLeft_y_2;
  logic        [31:0] height_window;

  logic        [11:0] score_bcd;
  logic        [2:0]  lives_left;
  logic               hit_pulse;
  logic               score_pulse;
  logic               invulnerable;
  logic               game_over;
  logic               playing;

  modport master (
    output frame_tick, start_key, bird_x, bird_y,
           topLeft_x_1, topLeft_y_1, topLeft_x_2, topLeft_y_2, height_window,
    input  score_bcd, lives_left, hit_pulse, score_pulse,
           invulnerable, game_over, playing
  );

  modport slave (
    input  frame_tick, start_key, bird_x, bird_y,
           topLeft_x_1, topLeft_y_1, topLeft_x_2, topLeft_y_2, height_window,
    output score_bcd, lives_left, hit_pulse, score_pulse,
           invulnerable, game_over, playing
  );

endinterface

// File: rtl/bcd_score_counter.sv
// Three-digit BCD score register: adds 0..2 per cycle with a rippled
// per-digit carry and saturates at 999 instead of wrapping.
module bcd_score_counter (
  input  logic        clk,
  input  logic        resetN,
  input  logic        clear,
  input  logic [1:0]  inc,
  output logic [11:0] score_bcd
);

  logic [11:0]      score_q;
  logic [11:0]      score_d;
  logic [3:0][1:0]  carry;
  logic [2:0][4:0]  digit_sum;
  logic [2:0][3:0]  digit_res;

  assign carry[0] = inc;

  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    assign digit_sum[gi] = {1'b0, score_q[4*gi +: 4]} + {3'b000, carry[gi]};
    assign carry[gi+1]   = (digit_sum[gi] >= 5'd10) ? 2'd1 : 2'd0;
    assign digit_res[gi] = (digit_sum[gi] >= 5'd10) ? 4'(digit_sum[gi] - 5'd10)
                                                    : digit_sum[gi][3:0];
  end

  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = 12'h000;
    end else if (inc != 2'd0) begin
      // A carry out of the hundreds digit means we crossed 999: pin there.
      score_d = (carry[3] != 2'd0) ? 12'h999 : {digit_res[2], digit_res[1], digit_res[0]};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q <= 12'h000;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_bcd = score_q;

endmodule

// File: rtl/collision_score_unit.sv
// Per-frame bird/building collision test, building-pass scoring and the
// IDLE/PLAY/INVULN/OVER game sequencer with lives and invulnerability.
module collision_score_unit #(
  parameter int WIDTH_BUILDING = flappy_pkg::WIDTH_BUILDING,
  parameter int WIDTH_BIRD     = 56,
  parameter int HEIGHT_BIRD    = 56,
  parameter int SCREEN_HEIGHT  = flappy_pkg::SCREEN_HEIGHT,
  parameter int LIVES          = 3,
  parameter int INVULN_FRAMES  = 90
) (
  input  logic                   clk,
  input  logic                   resetN,
  collision_score_unit_if.slave  bus
);

  import flappy_pkg::*;

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);

  localparam logic signed [32:0] W_BLD  = 33'(WIDTH_BUILDING);
  localparam logic signed [32:0] W_BIRD = 33'(WIDTH_BIRD);
  localparam logic signed [32:0] H_BIRD = 33'(HEIGHT_BIRD);
  localparam logic signed [32:0] SCR_H  = 33'(SCREEN_HEIGHT);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [INV_W-1:0]   INV_INIT   = INV_W'(INVULN_FRAMES);

  // Start key synchroniser and rising-edge detect
  logic start_meta_q, start_sync_q, start_prev_q;
  logic start_edge;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      start_meta_q <= bus.start_key;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  assign start_edge = start_sync_q & ~start_prev_q;

  game_state_t      state_q, state_d;
  logic [2:0]       lives_q, lives_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic             hit_pulse_q, hit_d;
  logic             score_pulse_q;
  logic             invulnerable_q, game_over_q, playing_q;
  logic             score_clear;
  logic [1:0]       score_inc;

  logic signed [32:0] bx, by, hw;
  logic signed [32:0] bld_x [2];
  logic signed [32:0] bld_y [2];
  logic signed [32:0] prev_x_q [2];
  logic signed [32:0] prev_x_d [2];
  logic [1:0]         passed_q, passed_d;
  logic [1:0]         overlap, miss, pass;
  logic               offscreen, hit_raw, scoring, start_ok;

  assign bx       = sext33(bus.bird_x);
  assign by       = sext33(bus.bird_y);
  assign hw       = sext33(bus.height_window);
  assign bld_x[0] = sext33(bus.topLeft_x_1);
  assign bld_y[0] = sext33(bus.topLeft_y_1);
  assign bld_x[1] = sext33(bus.topLeft_x_2);
  assign bld_y[1] = sext33(bus.topLeft_y_2);

  assign start_ok = start_edge && (state_q == IDLE || state_q == OVER);
  assign scoring  = bus.frame_tick && (state_q == PLAY || state_q == INVULN);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bld
    logic passed_eff;
    logic wrapped;

    assign overlap[gi] = (bx + W_BIRD > bld_x[gi]) && (bx < bld_x[gi] + W_BLD);
    assign miss[gi]    = (by < bld_y[gi]) || (by + H_BIRD > bld_y[gi] + hw);
    // A building moving right between ticks has wrapped and may be scored again
    assign wrapped     = bld_x[gi] > prev_x_q[gi];
    assign passed_eff  = passed_q[gi] & ~wrapped;
    assign pass[gi]    = scoring & ~passed_eff & (bld_x[gi] + W_BLD <= bx);

    always_comb begin
      prev_x_d[gi] = prev_x_q[gi];
      passed_d[gi] = passed_q[gi];
      if (bus.frame_tick) begin
        prev_x_d[gi] = bld_x[gi];
        passed_d[gi] = passed_eff | pass[gi];
      end
      if (start_ok) begin
        passed_d[gi] = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        prev_x_q[gi] <= '0;
        passed_q[gi] <= 1'b0;
      end else begin
        prev_x_q[gi] <= prev_x_d[gi];
        passed_q[gi] <= passed_d[gi];
      end
    end
  end

  assign offscreen = (by < 33'sd0) || (by + H_BIRD > SCR_H);
  assign hit_raw   = (overlap[0] & miss[0]) | (overlap[1] & miss[1]) | offscreen;
  assign score_inc = {pass[0] & pass[1], pass[0] ^ pass[1]};

  // Scoring is settled independently above, so a pass on a hit tick still counts
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    hit_d       = 1'b0;
    score_clear = 1'b0;
    if (start_ok) begin
      state_d     = PLAY;
      lives_d     = LIVES_INIT;
      inv_cnt_d   = '0;
      score_clear = 1'b1;
    end else if (bus.frame_tick) begin
      unique case (state_q)
        PLAY: begin
          if (hit_raw) begin
            hit_d = 1'b1;
            if (lives_q > 3'd1) begin
              state_d   = INVULN;
              lives_d   = lives_q - 3'd1;
              inv_cnt_d = INV_INIT;
            end else begin
              state_d = OVER;
              lives_d = 3'd0;
            end
          end
        end
        INVULN: begin
          inv_cnt_d = inv_cnt_q - INV_W'(1);
          if (inv_cnt_q <= INV_W'(1)) begin
            state_d = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      lives_q        <= LIVES_INIT;
      inv_cnt_q      <= '0;
      hit_pulse_q    <= 1'b0;
      score_pulse_q  <= 1'b0;
      invulnerable_q <= 1'b0;
      game_over_q    <= 1'b0;
      playing_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      inv_cnt_q      <= inv_cnt_d;
      hit_pulse_q    <= hit_d;
      score_pulse_q  <= |score_inc;
      invulnerable_q <= (state_d == INVULN);
      game_over_q    <= (state_d == OVER);
      playing_q      <= (state_d == PLAY) || (state_d == INVULN);
    end
  end

  logic [11:0] score_w;

  bcd_score_counter u_score (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (score_clear),
    .inc       (score_inc),
    .score_bcd (score_w)
  );

  assign bus.score_bcd    = score_w;
  assign bus.lives_left   = lives_q;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.score_pulse  = score_pulse_q;
  assign bus.invulnerable = invulnerable_q;
  assign bus.game_over    = game_over_q;
  assign bus.playing      = playing_q;

endmodule

// File: tb/tb_collision_score_unit.sv
// Directed bench: stimulus pushes expected pulse transactions into a queue,
// a monitor pops and compares whenever hit_pulse or score_pulse fires.
module tb_collision_score_unit;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  collision_score_unit_if bus ();

  collision_score_unit dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct packed {
    logic        hit;
    logic        sp;
    logic [11:0] score;
    logic [2:0]  lives;
    logic        inv;
    logic        over;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_act, mon_exp;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   txn_no = 0;

  always @(negedge clk) begin
    if (resetN === 1'b1 && (bus.hit_pulse === 1'b1 || bus.score_pulse === 1'b1)) begin
      mon_act = {bus.hit_pulse, bus.score_pulse, bus.score_bcd, bus.lives_left,
                 bus.invulnerable, bus.game_over};
      tests_run++;
      txn_no++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_pulse: got hit=%0b sp=%0b score=%03h lives=%0d inv=%0b over=%0b, required no pulse",
                 mon_act.hit, mon_act.sp, mon_act.score, mon_act.lives, mon_act.inv, mon_act.over);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          tests_failed++;
          $display("FAIL txn%0d: got hit=%0b sp=%0b score=%03h lives=%0d inv=%0b over=%0b, required hit=%0b sp=%0b score=%03h lives=%0d inv=%0b over=%0b",
                   txn_no, mon_act.hit, mon_act.sp, mon_act.score, mon_act.lives, mon_act.inv, mon_act.over,
                   mon_exp.hit, mon_exp.sp, mon_exp.score, mon_exp.lives, mon_exp.inv, mon_exp.over);
        end else begin
          $display("[TB] txn%0d ok hit=%0b sp=%0b score=%03h lives=%0d inv=%0b over=%0b",
                   txn_no, mon_act.hit, mon_act.sp, mon_act.score, mon_act.lives, mon_act.inv, mon_act.over);
        end
      end
    end
  end

  task automatic push(input logic h, input logic s, input logic [11:0] sc,
                      input logic [2:0] l, input logic i, input logic o);
    exp_t e;
    e = {h, s, sc, l, i, o};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_game();
    @(negedge clk);
    bus.start_key = 1'b1;
    repeat (6) @(negedge clk);
    bus.start_key = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_bld(input int x1, input int y1, input int x2, input int y2);
    bus.topLeft_x_1 = x1;
    bus.topLeft_y_1 = y1;
    bus.topLeft_x_2 = x2;
    bus.topLeft_y_2 = y2;
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN            = 1'b0;
    bus.frame_tick    = 1'b0;
    bus.start_key     = 1'b0;
    bus.bird_x        = 100;
    bus.bird_y        = 200;
    bus.height_window = 200;
    set_bld(600, 150, 600, 150);
    repeat (3) @(negedge clk);

    chk("reset_playing", {31'd0, bus.playing}, 32'd0);
    chk("reset_over", {31'd0, bus.game_over}, 32'd0);
    chk("reset_inv", {31'd0, bus.invulnerable}, 32'd0);
    chk("reset_lives", {29'd0, bus.lives_left}, 32'd3);
    chk("reset_score", {20'd0, bus.score_bcd}, 32'h000);
    chk("reset_pulses", {30'd0, bus.hit_pulse, bus.score_pulse}, 32'd0);
    resetN = 1'b1;

    // Start then idle frames: no pulses expected
    start_game();
    chk("start_playing", {31'd0, bus.playing}, 32'd1);
    chk("start_lives", {29'd0, bus.lives_left}, 32'd3);
    for (int i = 0; i < 10; i++) frame();

    // Single building pass, hold, wrap, pass again
    bus.topLeft_x_1 = 40;
    frame();
    bus.topLeft_x_1 = 20;
    push(1'b0, 1'b1, 12'h001, 3'd3, 1'b0, 1'b0);
    frame();
    for (int i = 0; i < 3; i++) frame();
    chk("pass_hold_score", {20'd0, bus.score_bcd}, 32'h001);
    bus.topLeft_x_1 = 639;
    frame();
    bus.topLeft_x_1 = 40;
    frame();
    bus.topLeft_x_1 = 20;
    push(1'b0, 1'b1, 12'h002, 3'd3, 1'b0, 1'b0);
    frame();
    chk("pass2_score", {20'd0, bus.score_bcd}, 32'h002);

    // Start edge while playing is ignored
    start_game();
    chk("start_in_play_score", {20'd0, bus.score_bcd}, 32'h002);
    chk("start_in_play_lives", {29'd0, bus.lives_left}, 32'd3);

    // Hit, 90 masked frames, second hit, 90 masked frames, fatal hit
    bus.topLeft_x_1 = 80;
    bus.topLeft_y_1 = 100;
    bus.bird_y      = 0;
    push(1'b1, 1'b0, 12'h002, 3'd2, 1'b1, 1'b0);
    frame();
    for (int i = 0; i < 89; i++) frame();
    chk("inv_after_89", {31'd0, bus.invulnerable}, 32'd1);
    frame();
    chk("inv_after_90", {31'd0, bus.invulnerable}, 32'd0);
    chk("play_after_90", {31'd0, bus.playing}, 32'd1);
    push(1'b1, 1'b0, 12'h002, 3'd1, 1'b1, 1'b0);
    frame();
    for (int i = 0; i < 90; i++) frame();
    push(1'b1, 1'b0, 12'h002, 3'd0, 1'b0, 1'b1);
    frame();
    chk("over_flag", {31'd0, bus.game_over}, 32'd1);
    chk("over_lives", {29'd0, bus.lives_left}, 32'd0);
    chk("over_playing", {31'd0, bus.playing}, 32'd0);
    for (int i = 0; i < 3; i++) frame();

    // Restart from OVER
    bus.bird_y = 200;
    set_bld(600, 150, 600, 150);
    start_game();
    chk("restart_score", {20'd0, bus.score_bcd}, 32'h000);
    chk("restart_lives", {29'd0, bus.lives_left}, 32'd3);
    chk("restart_over", {31'd0, bus.game_over}, 32'd0);
    chk("restart_playing", {31'd0, bus.playing}, 32'd1);
    frame();

    // Bottom edge: 424+56 == 480 is safe, 425 is a hit
    bus.bird_y = 424;
    frame();
    bus.bird_y = 425;
    push(1'b1, 1'b0, 12'h000, 3'd2, 1'b1, 1'b0);
    frame();
    bus.bird_y = 200;

    // Scoring continues while invulnerable
    bus.topLeft_x_1 = 40;
    frame();
    bus.topLeft_x_1 = 20;
    push(1'b0, 1'b1, 12'h001, 3'd2, 1'b1, 1'b0);
    frame();

    // Asynchronous reset in the middle of INVULN
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("midreset_inv", {31'd0, bus.invulnerable}, 32'd0);
    chk("midreset_score", {20'd0, bus.score_bcd}, 32'h000);
    chk("midreset_lives", {29'd0, bus.lives_left}, 32'd3);
    chk("midreset_playing", {31'd0, bus.playing}, 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Double passes up to 998, then saturation at 999
    start_game();
    for (int k = 1; k <= 501; k++) begin
      set_bld(639, 150, 639, 150);
      frame();
      set_bld(20, 150, 20, 150);
      push(1'b0, 1'b1, to_bcd((2 * k > 999) ? 999 : 2 * k), 3'd3, 1'b0, 1'b0);
      frame();
      if (k == 499) chk("score_998", {20'd0, bus.score_bcd}, 32'h998);
    end
    chk("score_sat", {20'd0, bus.score_bcd}, 32'h999);

    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_pulses: got %0d outstanding expected transactions, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
